// File: rtl/bus_seq_pkg.sv
// Shared types and constants for the bus sequencer: FSM states, fixed
// bus-source indices and the select-width helper.
package bus_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam int SRC_AR = 1;
  localparam int SRC_PC = 2;
  localparam int SRC_DR = 3;
  localparam int SRC_AC = 4;
  localparam int SRC_IR = 5;
  localparam int SRC_TR = 6;
  localparam int SRC_M  = 7;

  // A single source still needs a 1-bit select port.
  function automatic int sel_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bus_prio_enc.sv
// Highest-set-bit priority encoder for the common-bus select, with an
// optional multi-hot indication (MULTI_EN=0 ties it off).
module bus_prio_enc
  import bus_seq_pkg::*;
#(
  parameter int NUM_SRC  = 8,
  parameter bit MULTI_EN = 1'b0,
  localparam int SEL_W   = sel_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] i_vec,
  output logic [SEL_W-1:0]   o_sel,
  output logic               o_multi
);

  always_comb begin
    o_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (i_vec[i]) o_sel = SEL_W'(i);
    end
  end

  generate
    if (MULTI_EN) begin : g_multi
      // Clearing the lowest set bit leaves something only if two or more were set.
      assign o_multi = |(i_vec & (i_vec - {{(NUM_SRC-1){1'b0}}, 1'b1}));
    end else begin : g_no_multi
      assign o_multi = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/bus_sequencer.sv
// Sequence counter, timing vector, IR latch and common-bus source select.
// Macro BUS_SEQUENCER_CONFLICT_CHK_EN enables the sticky multi-driver flag.
module bus_sequencer
  import bus_seq_pkg::*;
#(
  parameter int SC_W    = 4,
  parameter int IR_W    = 16,
  parameter int NUM_SRC = 8,
  localparam int NUM_T  = 2**SC_W,
  localparam int SEL_W  = sel_w(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               halt_req,
  input  logic               sc_clr,
  input  logic               int_r,
  input  logic [IR_W-1:0]    ir_in,
  input  logic [NUM_SRC-1:0] ext_req,
  output logic [NUM_T-1:0]   t,
  output logic [7:0]         d,
  output logic               i_flag,
  output logic [NUM_SRC-1:0] bus_src,
  output logic [SEL_W-1:0]   bus_sel,
  output logic               running,
  output logic               sc_wrap,
  output logic               conflict
);

  state_t            r_state;
  logic [SC_W-1:0]   r_sc;
  logic [7:0]        r_d;
  logic              r_i;
  logic              r_wrap;
  logic [NUM_SRC-1:0] w_fixed;
  logic              w_multi;
  logic              w_unused_ir;

  assign w_unused_ir = ^ir_in[IR_W-5:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sc    <= '0;
      r_d     <= '0;
      r_i     <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      case (r_state)
        IDLE, HALT: begin
          if (start) begin
            r_state <= RUN;
            r_sc    <= '0;
          end
        end
        RUN: begin
          if (halt_req) begin
            r_state <= HALT;
            r_sc    <= '0;
          end else if (sc_clr) begin
            r_sc <= '0;
          end else begin
            r_sc <= r_sc + SC_W'(1);
            if (r_sc == SC_W'(NUM_T-1)) r_wrap <= 1'b1;
          end
          // Fetch latch at T2 of a normal (non-interrupt) cycle.
          if (!int_r && r_sc == SC_W'(2)) begin
            r_d <= 8'b1 << ir_in[IR_W-2:IR_W-4];
            r_i <= ir_in[IR_W-1];
          end
        end
        default: begin
          r_state <= IDLE;
          r_sc    <= '0;
        end
      endcase
    end
  end

  assign running = (r_state == RUN);
  assign t       = running ? (NUM_T'(1) << r_sc) : '0;
  assign d       = r_d;
  assign i_flag  = r_i;
  assign sc_wrap = r_wrap;

  always_comb begin
    w_fixed         = '0;
    w_fixed[SRC_AR] = (r_d[4] & t[4]) | (r_d[5] & t[5]);
    w_fixed[SRC_PC] = (r_d[5] & t[4]) | t[0];
    w_fixed[SRC_DR] = r_d[6] & t[6];
    w_fixed[SRC_AC] = r_d[3] & t[4];
    w_fixed[SRC_IR] = ~int_r & t[2];
    w_fixed[SRC_TR] = int_r & t[1];
    w_fixed[SRC_M]  = (~int_r & t[1]) | (~r_d[7] & r_i & t[3])
                    | ((r_d[0] | r_d[1] | r_d[2]) & t[4]);
  end

  assign bus_src = w_fixed | ext_req;

`ifdef BUS_SEQUENCER_CONFLICT_CHK_EN
  localparam bit MULTI_EN = 1'b1;
  logic r_conflict;

  always_ff @(posedge clk) begin
    if (rst)                  r_conflict <= 1'b0;
    else if (running && w_multi) r_conflict <= 1'b1;
  end

  assign conflict = r_conflict;
`else
  localparam bit MULTI_EN = 1'b0;
  assign conflict = w_multi;
`endif

  bus_prio_enc #(
    .NUM_SRC  (NUM_SRC),
    .MULTI_EN (MULTI_EN)
  ) u_prio_enc (
    .i_vec   (bus_src),
    .o_sel   (bus_sel),
    .o_multi (w_multi)
  );

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed self-checking bench for bus_sequencer (default parameters).
module tb_bus_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, halt_req, sc_clr, int_r;
  logic [15:0] ir_in;
  logic [7:0]  ext_req;
  logic [15:0] t;
  logic [7:0]  d;
  logic        i_flag;
  logic [7:0]  bus_src;
  logic [2:0]  bus_sel;
  logic        running, sc_wrap, conflict;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bus_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .halt_req (halt_req),
    .sc_clr   (sc_clr),
    .int_r    (int_r),
    .ir_in    (ir_in),
    .ext_req  (ext_req),
    .t        (t),
    .d        (d),
    .i_flag   (i_flag),
    .bus_src  (bus_src),
    .bus_sel  (bus_sel),
    .running  (running),
    .sc_wrap  (sc_wrap),
    .conflict (conflict)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    logic exp_conf;
`ifdef BUS_SEQUENCER_CONFLICT_CHK_EN
    exp_conf = 1'b1;
`else
    exp_conf = 1'b0;
`endif
    rst = 1'b1; start = 1'b0; halt_req = 1'b0; sc_clr = 1'b0; int_r = 1'b0;
    ir_in = 16'h0000; ext_req = 8'h00;
    step(); step();
    check("rst_t", 32'(t), 32'h0);
    check("rst_running", 32'(running), 32'h0);
    check("rst_d", 32'(d), 32'h0);
    check("rst_i", 32'(i_flag), 32'h0);
    check("rst_wrap", 32'(sc_wrap), 32'h0);
    check("rst_conflict", 32'(conflict), 32'h0);
    check("rst_bus_src", 32'(bus_src), 32'h0);
    check("rst_bus_sel", 32'(bus_sel), 32'h0);

    // Idle without start stays idle
    rst = 1'b0;
    step();
    check("idle_t", 32'(t), 32'h0);

    // Start, full walk and wrap
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_t0", 32'(t), 32'h0001);
    check("start_running", 32'(running), 32'h1);
    for (int k = 1; k < 16; k++) begin
      step();
      check($sformatf("walk_t%0d", k), 32'(t), 32'h1 << k);
      check($sformatf("walk_wrap%0d", k), 32'(sc_wrap), 32'h0);
    end
    step();
    check("wrap_t0", 32'(t), 32'h0001);
    check("wrap_pulse", 32'(sc_wrap), 32'h1);
    step();
    check("wrap_t1", 32'(t), 32'h0002);
    check("wrap_pulse_end", 32'(sc_wrap), 32'h0);

    // sc_clr realigns to T0
    sc_clr = 1'b1;
    step();
    sc_clr = 1'b0;
    check("clr_t0", 32'(t), 32'h0001);
    check("clr_wrap", 32'(sc_wrap), 32'h0);

    // Opcode 2, direct
    ir_in = 16'h2123;
    check("op2_t0_src", 32'(bus_src), 32'h04);
    check("op2_t0_sel", 32'(bus_sel), 32'd2);
    step();
    check("op2_t1_sel", 32'(bus_sel), 32'd7);
    step();
    check("op2_t2_src", 32'(bus_src), 32'h20);
    check("op2_t2_sel", 32'(bus_sel), 32'd5);
    step();
    check("op2_t3_d", 32'(d), 32'h04);
    check("op2_t3_i", 32'(i_flag), 32'h0);
    check("op2_t3_src", 32'(bus_src), 32'h00);
    check("op2_t3_sel", 32'(bus_sel), 32'd0);
    step();
    check("op2_t4_src", 32'(bus_src), 32'h80);
    check("op2_t4_sel", 32'(bus_sel), 32'd7);

    // Opcode 0, indirect
    sc_clr = 1'b1;
    step();
    sc_clr = 1'b0;
    ir_in = 16'h8123;
    step(); step(); step();
    check("ind_t3_t", 32'(t), 32'h0008);
    check("ind_t3_i", 32'(i_flag), 32'h1);
    check("ind_t3_d", 32'(d), 32'h01);
    check("ind_t3_src", 32'(bus_src), 32'h80);
    check("ind_t3_sel", 32'(bus_sel), 32'd7);

    // Interrupt cycle: TR instead of M, no latch at T2
    sc_clr = 1'b1;
    step();
    sc_clr = 1'b0;
    int_r = 1'b1;
    check("int_t0_sel", 32'(bus_sel), 32'd2);
    step();
    check("int_t1_src", 32'(bus_src), 32'h40);
    check("int_t1_sel", 32'(bus_sel), 32'd6);
    ir_in = 16'h7000;
    step();
    check("int_t2_src", 32'(bus_src), 32'h00);
    step();
    check("int_t3_d", 32'(d), 32'h01);
    check("int_t3_i", 32'(i_flag), 32'h1);
    check("int_t3_src", 32'(bus_src), 32'h80);
    int_r = 1'b0;

    // halt_req with sc_clr: halt wins
    halt_req = 1'b1; sc_clr = 1'b1;
    step();
    halt_req = 1'b0; sc_clr = 1'b0;
    check("halt_t", 32'(t), 32'h0);
    check("halt_running", 32'(running), 32'h0);
    check("halt_src", 32'(bus_src), 32'h00);
    step();
    check("halt_hold_t", 32'(t), 32'h0);
    check("halt_hold_d", 32'(d), 32'h01);
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_t", 32'(t), 32'h0001);
    check("restart_running", 32'(running), 32'h1);

    // start while running is ignored
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_ign_t", 32'(t), 32'h0004);
    step();
    check("op7_d", 32'(d), 32'h80);
    check("op7_i", 32'(i_flag), 32'h0);
    check("op7_t3_src", 32'(bus_src), 32'h00);

    // D3 at T4 with an external driver on bit 3
    sc_clr = 1'b1;
    step();
    sc_clr = 1'b0;
    ir_in = 16'h3000;
    step(); step(); step();
    check("op3_d", 32'(d), 32'h08);
    ext_req = 8'h01 << 3;
    step();
    check("multi_src", 32'(bus_src), 32'h18);
    check("multi_sel", 32'(bus_sel), 32'd4);
    check("multi_conflict_pre", 32'(conflict), 32'h0);
    ext_req = 8'h00;
    step();
    check("conflict_set", 32'(conflict), 32'(exp_conf));
    check("ext_clear_src", 32'(bus_src), 32'h00);
    step();
    check("conflict_sticky", 32'(conflict), 32'(exp_conf));

    // Mid-instruction reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_t", 32'(t), 32'h0);
    check("rst2_d", 32'(d), 32'h0);
    check("rst2_i", 32'(i_flag), 32'h0);
    check("rst2_conflict", 32'(conflict), 32'h0);
    check("rst2_running", 32'(running), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
